// File: rtl/logic_unit_acc.sv
// logic_unit_acc -- WIDTH-bit logic/arithmetic unit with an accumulator.
//
// One operation is issued per accepted start pulse. Logic, arithmetic and
// LOAD ops finish at the accepting edge. SHL is a serial shift that moves one
// bit position per cycle. The start/busy/done handshake reports when acc is valid.
//
// Compile-time option:
//   LOGIC_UNIT_OVF_EN  when defined, adds the registered output ovf. It is the
//                      signed two's-complement overflow flag for ADD and SUB,
//                      and every other accepted op clears it.
module logic_unit_acc #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             sign,
`ifdef LOGIC_UNIT_OVF_EN
    output logic             ovf,
`endif
    output logic             carry
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOT  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_SHL  = 3'b110,
        OP_LOAD = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;

    // ------------------------------------------------------------------
    // Shared decode of the current request
    // ------------------------------------------------------------------
    op_e              op_sel;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [CW-1:0]    shamt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    assign op_sel = op_e'(op);
    // start is only honoured while idle; requests made during a shift are dropped.
    assign accept = (state_q == ST_IDLE) && start;
    assign a_sel  = use_acc ? acc_q : a;
    assign shamt  = b[CW-1:0];
    // One extra bit holds the carry of the sum.
    // On the difference the extra bit is the borrow (set iff a_sel < b).
    assign sum    = {1'b0, a_sel} + {1'b0, b};
    assign diff   = {1'b0, a_sel} - {1'b0, b};

    // State register: synchronous reset returns to IDLE and aborts any shift.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples
        // pre-edge values; blocking here would make results depend on block order.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a non-zero SHL leaves IDLE, and the final shift step returns.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && (op_sel == OP_SHL) && (shamt != CNT_ZERO)) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: an accepted op or a shift step updates acc, carry, counter and done.
    always_comb begin
        // NOTE: each output of this block gets a default first, so no path
        // through the case statements leaves a value unassigned and no latch is inferred.
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (state_q == ST_SHIFT) begin
            carry_d = acc_q[WIDTH-1];
            acc_d   = {acc_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_ONE;
            done_d  = (cnt_q == CNT_ONE);
        end else if (accept) begin
            done_d = 1'b1;
            unique case (op_sel)
                OP_AND: begin
                    acc_d   = a_sel & b;
                    carry_d = 1'b0;
                end
                OP_OR: begin
                    acc_d   = a_sel | b;
                    carry_d = 1'b0;
                end
                OP_XOR: begin
                    acc_d   = a_sel ^ b;
                    carry_d = 1'b0;
                end
                OP_NOT: begin
                    acc_d   = ~a_sel;
                    carry_d = 1'b0;
                end
                OP_ADD: begin
                    acc_d   = sum[WIDTH-1:0];
                    carry_d = sum[WIDTH];
                end
                OP_SUB: begin
                    acc_d   = diff[WIDTH-1:0];
                    carry_d = diff[WIDTH];
                end
                OP_SHL: begin
                    // Load the operand now; the SHIFT state does the shifting.
                    // A zero count finishes immediately, like a single-cycle op.
                    acc_d   = a_sel;
                    carry_d = 1'b0;
                    cnt_d   = shamt;
                    done_d  = (shamt == CNT_ZERO);
                end
                OP_LOAD: begin
                    acc_d   = b;
                    carry_d = 1'b0;
                end
                default: begin
                    acc_d   = acc_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    // Datapath registers: all cleared by reset, so an aborted shift produces no done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef LOGIC_UNIT_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow next value: signed overflow for ADD/SUB; any other accepted op clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            unique case (op_sel)
                OP_ADD:  ovf_d = (a_sel[WIDTH-1] == b[WIDTH-1]) &&
                                 (sum[WIDTH-1] != a_sel[WIDTH-1]);
                OP_SUB:  ovf_d = (a_sel[WIDTH-1] != b[WIDTH-1]) &&
                                 (diff[WIDTH-1] != a_sel[WIDTH-1]);
                default: ovf_d = 1'b0;
            endcase
        end
    end

    // Overflow register: it keeps its value through shift steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    // Outputs: registered values plus the combinational zero and sign flags of the accumulator.
    always_comb begin
        acc   = acc_q;
        carry = carry_q;
        done  = done_q;
        busy  = (state_q == ST_SHIFT);
        zero  = (acc_q == '0);
        sign  = acc_q[WIDTH-1];
    end

endmodule

// File: tb/tb_logic_unit_acc.sv
// Testbench for logic_unit_acc (WIDTH = 8).
// A behavioural model computes expected outputs from the operation rules and
// is compared with the DUT on every falling edge. Directed sequences with
// literal expectations pin the model, and a randomized phase follows.
module tb_logic_unit_acc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic         use_acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] acc;
    logic         busy;
    logic         done;
    logic         zero;
    logic         sign;
    logic         carry;
`ifdef LOGIC_UNIT_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic_unit_acc #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .use_acc (use_acc),
        .a       (a),
        .b       (b),
        .acc     (acc),
        .busy    (busy),
        .done    (done),
        .zero    (zero),
        .sign    (sign),
`ifdef LOGIC_UNIT_OVF_EN
        .ovf     (ovf),
`endif
        .carry   (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic         live = 1'b0;
    logic [W-1:0] m_acc;
    logic         m_carry;
    logic         m_done;
    logic         m_busy;
    logic         m_ovf;
    logic [W-1:0] sh_base;
    int           sh_k;
    int           sh_step;

    always @(posedge clk) begin : model
        logic [W-1:0] as;
        int           s;
        int           ss;
        live   = 1'b1;
        m_done = 1'b0;
        if (reset) begin
            m_acc   = '0;
            m_carry = 1'b0;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_busy) begin
            // After j steps, acc holds the operand shifted left by j positions.
            // carry holds the last bit that was shifted out.
            sh_step = sh_step + 1;
            m_acc   = W'(sh_base << sh_step);
            m_carry = sh_base[W - sh_step];
            if (sh_step == sh_k) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else if (start) begin
            as      = use_acc ? m_acc : a;
            m_done  = 1'b1;
            m_ovf   = 1'b0;
            m_carry = 1'b0;
            case (op)
                3'd0: m_acc = as & b;
                3'd1: m_acc = as | b;
                3'd2: m_acc = as ^ b;
                3'd3: m_acc = ~as;
                3'd4: begin
                    s       = int'(as) + int'(b);
                    m_acc   = W'(s);
                    m_carry = (s > 255);
                    ss      = int'($signed(as)) + int'($signed(b));
                    m_ovf   = (ss > 127) || (ss < -128);
                end
                3'd5: begin
                    s       = int'(as) - int'(b);
                    m_acc   = W'(s);
                    m_carry = (as < b);
                    ss      = int'($signed(as)) - int'($signed(b));
                    m_ovf   = (ss > 127) || (ss < -128);
                end
                3'd6: begin
                    m_acc = as;
                    sh_k  = int'(b) % W;
                    if (sh_k != 0) begin
                        m_busy  = 1'b1;
                        m_done  = 1'b0;
                        sh_base = as;
                        sh_step = 0;
                    end
                end
                default: m_acc = b;
            endcase
        end
    end

    // Compare process: the DUT outputs are checked against the model on every falling edge.
    always @(negedge clk) begin
        if (live) begin
            check("m_acc",   32'(acc),   32'(m_acc));
            check("m_busy",  32'(busy),  32'(m_busy));
            check("m_done",  32'(done),  32'(m_done));
            check("m_zero",  32'(zero),  32'(m_acc == '0));
            check("m_sign",  32'(sign),  32'(m_acc[W-1]));
            check("m_carry", 32'(carry), 32'(m_carry));
`ifdef LOGIC_UNIT_OVF_EN
            check("m_ovf",   32'(ovf),   32'(m_ovf));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Drive one start pulse for one cycle. The task returns at the falling edge
    // after the accepting edge, which is where a single-cycle op shows done.
    task automatic issue(input logic [2:0] o, input logic ua, input logic [W-1:0] av,
                         input logic [W-1:0] bv);
        @(negedge clk);
        start   = 1'b1;
        op      = o;
        use_acc = ua;
        a       = av;
        b       = bv;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Count cycles, including the current one, until done is seen, and count
    // the busy cycles along the way. The wait is bounded.
    task automatic wait_done(output int lat, output int bc);
        lat = 1;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int bc;
    int seen;

    initial begin
        // Reset dominates a simultaneous start request.
        reset = 1'b1; start = 1'b1; op = 3'b111; use_acc = 1'b0; a = 8'h00; b = 8'hA5;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_acc",   32'(acc),   32'h00);
        check("rst_zero",  32'(zero),  32'h1);
        check("rst_carry", 32'(carry), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_done",  32'(done),  32'h0);
        reset = 1'b0; start = 1'b0;

        // LOAD, then AND with the accumulator as operand A.
        issue(3'b111, 1'b0, 8'h00, 8'hA5);
        check("load_acc",  32'(acc),  32'hA5);
        check("load_done", 32'(done), 32'h1);
        issue(3'b000, 1'b1, 8'h00, 8'h0F);
        check("and_acc",   32'(acc),   32'h05);
        check("and_carry", 32'(carry), 32'h0);

        // ADD and SUB: carry is the carry-out of ADD and the borrow of SUB.
        issue(3'b100, 1'b0, 8'hF0, 8'h20);
        check("add_acc",   32'(acc),   32'h10);
        check("add_carry", 32'(carry), 32'h1);
        issue(3'b101, 1'b1, 8'h00, 8'h20);
        check("sub_acc",   32'(acc),   32'hF0);
        check("sub_carry", 32'(carry), 32'h1);
        issue(3'b101, 1'b0, 8'h20, 8'h20);
        check("sub0_acc",   32'(acc),   32'h00);
        check("sub0_zero",  32'(zero),  32'h1);
        check("sub0_carry", 32'(carry), 32'h0);

        // SHL by 3, by 1 and by 0.
        issue(3'b110, 1'b0, 8'h81, 8'h03);
        wait_done(lat, bc);
        check("shl3_lat",   32'(lat),   32'd4);
        check("shl3_busy",  32'(bc),    32'd3);
        check("shl3_acc",   32'(acc),   32'h08);
        check("shl3_carry", 32'(carry), 32'h0);
        issue(3'b110, 1'b0, 8'h81, 8'h01);
        wait_done(lat, bc);
        check("shl1_lat",   32'(lat),   32'd2);
        check("shl1_acc",   32'(acc),   32'h02);
        check("shl1_carry", 32'(carry), 32'h1);
        issue(3'b110, 1'b0, 8'h81, 8'h00);
        wait_done(lat, bc);
        check("shl0_lat",  32'(lat), 32'd1);
        check("shl0_busy", 32'(bc),  32'd0);
        check("shl0_acc",  32'(acc), 32'h81);

        // A start pulse during a shift is ignored.
        issue(3'b110, 1'b0, 8'h81, 8'h03);
        start = 1'b1; op = 3'b111; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("ign_lat", 32'(lat), 32'd3);
        check("ign_acc", 32'(acc), 32'h08);

        // Reset in the middle of a shift aborts it, with no done pulse.
        issue(3'b110, 1'b0, 8'hFF, 8'h05);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_acc",  32'(acc),  32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_nodone", 32'(seen), 32'd0);

`ifdef LOGIC_UNIT_OVF_EN
        issue(3'b100, 1'b0, 8'h7F, 8'h01);
        check("ovf_add_acc",   32'(acc),   32'h80);
        check("ovf_add_sign",  32'(sign),  32'h1);
        check("ovf_add_ovf",   32'(ovf),   32'h1);
        check("ovf_add_carry", 32'(carry), 32'h0);
        issue(3'b101, 1'b0, 8'h80, 8'h01);
        check("ovf_sub_acc", 32'(acc), 32'h7F);
        check("ovf_sub_ovf", 32'(ovf), 32'h1);
        issue(3'b000, 1'b1, 8'h00, 8'hFF);
        check("ovf_and_ovf", 32'(ovf), 32'h0);
`endif

        // Randomized phase: random ops, operands, start pulses and occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 63) == 0);
            start   = 1'($urandom_range(0, 1));
            op      = 3'($urandom);
            use_acc = 1'($urandom_range(0, 1));
            a       = W'($urandom);
            b       = W'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (10) @(negedge clk);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
